// File: rtl/jtag_shift_ctrl_if.sv
// Command/status bus between the VME JTAG command decoder (master) and the
// chain sequencer (slave).
interface jtag_shift_ctrl_if;
  logic        STRB;
  logic        RESET_CMD;
  logic        INSTR;
  logic        HEADER;
  logic        TRAILER;
  logic [3:0]  NBITS;
  logic [15:0] DIN;
  logic        BUSY;
  logic        DONE;
  logic [15:0] TDO_REG;

  modport master (
    output STRB, RESET_CMD, INSTR, HEADER, TRAILER, NBITS, DIN,
    input  BUSY, DONE, TDO_REG
  );

  modport slave (
    input  STRB, RESET_CMD, INSTR, HEADER, TRAILER, NBITS, DIN,
    output BUSY, DONE, TDO_REG
  );
endinterface

// File: rtl/jtag_shift_ctrl.sv
// JTAG chain sequencer: runs one VME JTAG command (TAP reset or a 1-16 bit
// shift with optional IR/DR header and trailer) and captures TDO.
module jtag_shift_ctrl #(
  parameter int CLKDIV = 2
) (
  input  logic               FPGACLK,
  input  logic               RST_B,
  input  logic               TDO,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  jtag_shift_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, TRST, HDR, SHIFT, TRL} state_e;

  localparam logic [3:0] DIV_LAST = 4'(CLKDIV - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        hi_q;
  logic [3:0]  bit_q;
  logic        instr_q;
  logic        trailer_q;
  logic [3:0]  nbits_q;
  logic [15:0] din_q;
  logic        tck_q;
  logic        tms_q;
  logic        tdi_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] tdo_reg_q;

  state_e      start_d;
  state_e      next_d;

  function automatic logic [3:0] last_idx(state_e s, logic instr, logic [3:0] nbits);
    case (s)
      TRST:    return 4'd5;
      HDR:     return instr ? 4'd3 : 4'd2;
      SHIFT:   return nbits;
      TRL:     return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic tms_at(state_e s, logic [3:0] k, logic instr,
                                  logic trailer, logic [3:0] nbits);
    case (s)
      TRST:    return (k != 4'd5);
      HDR:     return instr ? (k < 4'd2) : (k == 4'd0);
      SHIFT:   return trailer && (k == nbits);
      TRL:     return (k == 4'd0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic tdi_at(state_e s, logic [3:0] k, logic [15:0] din);
    return (s == SHIFT) ? din[k] : 1'b0;
  endfunction

  function automatic state_e next_of(state_e s, logic trailer);
    case (s)
      HDR:     return SHIFT;
      SHIFT:   return trailer ? TRL : IDLE;
      default: return IDLE;
    endcase
  endfunction

  assign start_d = bus.RESET_CMD ? TRST : (bus.HEADER ? HDR : SHIFT);
  assign next_d  = next_of(state_q, trailer_q);

  // Sequencer: TCK phase timing, TMS/TDI generation, TDO capture, handshake.
  always_ff @(posedge FPGACLK) begin
    if (!RST_B) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 1'b0;
      bit_q     <= 4'd0;
      instr_q   <= 1'b0;
      trailer_q <= 1'b0;
      nbits_q   <= 4'd0;
      din_q     <= 16'h0000;
      tck_q     <= 1'b0;
      tms_q     <= 1'b0;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tdo_reg_q <= 16'h0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tck_q <= 1'b0;
          if (bus.STRB) begin
            state_q   <= start_d;
            instr_q   <= bus.INSTR;
            trailer_q <= bus.TRAILER;
            nbits_q   <= bus.NBITS;
            din_q     <= bus.DIN;
            busy_q    <= 1'b1;
            cnt_q     <= 4'd0;
            hi_q      <= 1'b0;
            bit_q     <= 4'd0;
            tms_q     <= tms_at(start_d, 4'd0, bus.INSTR, bus.TRAILER, bus.NBITS);
            tdi_q     <= tdi_at(start_d, 4'd0, bus.DIN);
            // Bits above the new shift length must not show stale capture data.
            if (!bus.RESET_CMD) begin
              tdo_reg_q <= tdo_reg_q & ~(16'hFFFE << bus.NBITS);
            end
          end
        end
        default: begin
          if (cnt_q != DIV_LAST) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            cnt_q <= 4'd0;
            if (!hi_q) begin
              hi_q  <= 1'b1;
              tck_q <= 1'b1;
            end else begin
              hi_q  <= 1'b0;
              tck_q <= 1'b0;
              if (state_q == SHIFT) begin
                tdo_reg_q[bit_q] <= TDO;
              end
              if (bit_q != last_idx(state_q, instr_q, nbits_q)) begin
                bit_q <= bit_q + 4'd1;
                tms_q <= tms_at(state_q, bit_q + 4'd1, instr_q, trailer_q, nbits_q);
                tdi_q <= tdi_at(state_q, bit_q + 4'd1, din_q);
              end else if (next_d == IDLE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                tms_q   <= 1'b0;
                tdi_q   <= 1'b0;
              end else begin
                state_q <= next_d;
                bit_q   <= 4'd0;
                tms_q   <= tms_at(next_d, 4'd0, instr_q, trailer_q, nbits_q);
                tdi_q   <= tdi_at(next_d, 4'd0, din_q);
              end
            end
          end
        end
      endcase
    end
  end

  assign TCK         = tck_q;
  assign TMS         = tms_q;
  assign TDI         = tdi_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.TDO_REG = tdo_reg_q;

endmodule

// File: tb/tb_jtag_shift_ctrl.sv
// Self-checking bench for jtag_shift_ctrl: expected TMS/TDI per TCK rising
// edge are queued when a command is issued and compared as TCK rises.
module tb_jtag_shift_ctrl;
  localparam int CLKDIV = 2;
  localparam int BOUND  = 500;

  logic FPGACLK;
  logic RST_B;
  logic TCK, TMS, TDI, TDO;
  logic loop_en, tdo_val, tck_prev;
  logic [2:0] exp_q[$];
  logic [2:0] e;
  int vectors, miscompares;

  jtag_shift_ctrl_if bus_if();

  jtag_shift_ctrl #(.CLKDIV(CLKDIV)) dut (
    .FPGACLK (FPGACLK),
    .RST_B   (RST_B),
    .TDO     (TDO),
    .TCK     (TCK),
    .TMS     (TMS),
    .TDI     (TDI),
    .bus     (bus_if)
  );

  assign TDO = loop_en ? TDI : tdo_val;

  initial FPGACLK = 1'b0;
  always #5 FPGACLK = ~FPGACLK;

  // Scoreboard consumer: every TCK rise pops one expected {chk_tdi, tms, tdi}.
  initial begin
    tck_prev = 1'b0;
    forever begin
      @(negedge FPGACLK);
      if (RST_B === 1'b1 && TCK === 1'b1 && tck_prev === 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tck_extra: unexpected TCK rise at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (TMS !== e[1]) begin
            miscompares++;
            $display("FAIL tms: got %b want %b at %0t", TMS, e[1], $time);
          end
          if (e[2]) begin
            vectors++;
            if (TDI !== e[0]) begin
              miscompares++;
              $display("FAIL tdi: got %b want %b at %0t", TDI, e[0], $time);
            end
          end
        end
      end
      tck_prev = TCK;
    end
  end

  task automatic push_cmd(input bit rc, input bit ins, input bit hdr, input bit trl,
                          input logic [3:0] nb, input logic [15:0] d);
    logic [3:0] seq;
    int cnt;
    if (rc) begin
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, (i < 5) ? 1'b1 : 1'b0, 1'b0});
    end else begin
      if (hdr) begin
        seq = ins ? 4'b0011 : 4'b0001;
        cnt = ins ? 4 : 3;
        for (int i = 0; i < cnt; i++) exp_q.push_back({1'b0, seq[i], 1'b0});
      end
      for (int k = 0; k <= int'(nb); k++)
        exp_q.push_back({1'b1, (trl && k == int'(nb)) ? 1'b1 : 1'b0, d[k]});
      if (trl) begin
        exp_q.push_back({1'b0, 1'b1, 1'b0});
        exp_q.push_back({1'b0, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic drive_cmd(input bit rc, input bit ins, input bit hdr, input bit trl,
                           input logic [3:0] nb, input logic [15:0] d);
    bus_if.RESET_CMD = rc;
    bus_if.INSTR     = ins;
    bus_if.HEADER    = hdr;
    bus_if.TRAILER   = trl;
    bus_if.NBITS     = nb;
    bus_if.DIN       = d;
  endtask

  task automatic send(input bit rc, input bit ins, input bit hdr, input bit trl,
                      input logic [3:0] nb, input logic [15:0] d);
    push_cmd(rc, ins, hdr, trl, nb, d);
    @(negedge FPGACLK);
    drive_cmd(rc, ins, hdr, trl, nb, d);
    bus_if.STRB = 1'b1;
    @(negedge FPGACLK);
    bus_if.STRB = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt, output bit got);
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (bus_if.DONE === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bus_if.BUSY === 1'b1) busy_cnt++;
      @(negedge FPGACLK);
    end
  endtask

  task automatic test_reset;
    RST_B = 1'b0;
    repeat (3) @(negedge FPGACLK);
    vectors += 6;
    if (TCK !== 1'b0) begin miscompares++; $display("FAIL rst_tck: got %b want 0", TCK); end
    if (TMS !== 1'b0) begin miscompares++; $display("FAIL rst_tms: got %b want 0", TMS); end
    if (TDI !== 1'b0) begin miscompares++; $display("FAIL rst_tdi: got %b want 0", TDI); end
    if (bus_if.BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus_if.BUSY); end
    if (bus_if.DONE !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", bus_if.DONE); end
    if (bus_if.TDO_REG !== 16'h0000) begin
      miscompares++; $display("FAIL rst_tdo_reg: got %h want 0000", bus_if.TDO_REG);
    end
    RST_B = 1'b1;
  endtask

  task automatic check_cmd(input string name, input int exp_busy, input logic [15:0] exp_tdo,
                           input bit chk_tdo);
    int b;
    bit got;
    wait_done(b, got);
    vectors += 4;
    if (!got) begin miscompares++; $display("FAIL %s_done: no DONE within %0d cycles", name, BOUND); end
    if (bus_if.BUSY !== 1'b0) begin miscompares++; $display("FAIL %s_busy_at_done: got %b want 0", name, bus_if.BUSY); end
    if (b != exp_busy) begin miscompares++; $display("FAIL %s_busy_len: got %0d want %0d", name, b, exp_busy); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL %s_tck_count: %0d TCKs missing", name, exp_q.size()); end
    if (chk_tdo) begin
      vectors++;
      if (bus_if.TDO_REG !== exp_tdo) begin
        miscompares++; $display("FAIL %s_tdo_reg: got %h want %h", name, bus_if.TDO_REG, exp_tdo);
      end
    end
  endtask

  task automatic test_tap_reset;
    loop_en = 1'b0; tdo_val = 1'b0;
    send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    check_cmd("tap_reset", 24, 16'h0000, 1'b1);
  endtask

  task automatic test_dr_loopback;
    loop_en = 1'b1;
    send(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 16'hC3A5);
    check_cmd("dr_full", 84, 16'hC3A5, 1'b1);
  endtask

  task automatic test_ir_short;
    loop_en = 1'b0; tdo_val = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 16'h0000);
    check_cmd("preload", 64, 16'hFFFF, 1'b1);
    send(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 16'h0002);
    check_cmd("ir_short", 36, 16'h001F, 1'b1);
  endtask

  task automatic test_back_to_back;
    int b, first_rise, idx;
    bit got;
    loop_en = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0009);
    check_cmd("b2b_a", 16, 16'h0009, 1'b1);
    // Strobe the next command in the DONE cycle, then a stray strobe mid-command.
    push_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 16'h005A);
    drive_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 16'h005A);
    bus_if.STRB = 1'b1;
    b = 0; first_rise = -1; got = 1'b0;
    for (idx = 1; idx < BOUND; idx++) begin
      @(negedge FPGACLK);
      if (idx == 1) bus_if.STRB = 1'b0;
      if (idx == 5) begin
        drive_cmd(1'b1, 1'b1, 1'b1, 1'b1, 4'd15, 16'hFFFF);
        bus_if.STRB = 1'b1;
      end
      if (idx == 6) bus_if.STRB = 1'b0;
      if (TCK === 1'b1 && first_rise < 0) first_rise = idx;
      if (bus_if.DONE === 1'b1) begin got = 1'b1; break; end
      if (bus_if.BUSY === 1'b1) b++;
    end
    drive_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    vectors += 5;
    if (!got) begin miscompares++; $display("FAIL b2b_b_done: no DONE within %0d cycles", BOUND); end
    if (first_rise != CLKDIV + 1) begin
      miscompares++; $display("FAIL b2b_gap: first TCK at cycle %0d want %0d", first_rise, CLKDIV + 1);
    end
    if (b != 32) begin miscompares++; $display("FAIL b2b_b_busy_len: got %0d want 32", b); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_b_tck_count: %0d TCKs missing", exp_q.size()); end
    if (bus_if.TDO_REG !== 16'h005A) begin
      miscompares++; $display("FAIL b2b_b_tdo_reg: got %h want 005A", bus_if.TDO_REG);
    end
  endtask

  task automatic test_abort;
    int dones;
    loop_en = 1'b1;
    send(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 16'hFFFF);
    repeat (16) @(negedge FPGACLK);
    RST_B = 1'b0;
    @(negedge FPGACLK);
    exp_q.delete();
    vectors += 6;
    if (TCK !== 1'b0) begin miscompares++; $display("FAIL abort_tck: got %b want 0", TCK); end
    if (TMS !== 1'b0) begin miscompares++; $display("FAIL abort_tms: got %b want 0", TMS); end
    if (TDI !== 1'b0) begin miscompares++; $display("FAIL abort_tdi: got %b want 0", TDI); end
    if (bus_if.BUSY !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", bus_if.BUSY); end
    if (bus_if.DONE !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", bus_if.DONE); end
    if (bus_if.TDO_REG !== 16'h0000) begin
      miscompares++; $display("FAIL abort_tdo_reg: got %h want 0000", bus_if.TDO_REG);
    end
    repeat (2) @(negedge FPGACLK);
    RST_B = 1'b1;
    dones = 0;
    repeat (100) begin
      @(negedge FPGACLK);
      if (bus_if.DONE === 1'b1 || bus_if.BUSY === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    RST_B = 1'b0; loop_en = 1'b0; tdo_val = 1'b0;
    bus_if.STRB = 1'b0;
    drive_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    test_reset();
    test_tap_reset();
    test_dr_loopback();
    test_ir_short();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtag_shift_ctrl.md
Name: jtag_shift_ctrl

Overview:
- Sequences one JTAG chain (CFEB, control FPGA, controller PROM or VME PROM) on behalf of the VME command decoder.
- Each VME JTAG command is one request: TAP reset, or a shift of 1-16 bits with an optional IR/DR header and an optional trailer.
- Generates TCK/TMS/TDI, captures TDO into a readback register, and signals completion to the VME DTACK logic.

Parameters:
- CLKDIV, 2, FPGACLK cycles per TCK half-period (legal values 1-15).

Ports:
- FPGACLK  input  1  system clock.
- RST_B  input  1  synchronous reset, active low.
- STRB  input  1  one-cycle command strobe.
- RESET_CMD  input  1  command is a TAP reset; NBITS, INSTR, HEADER, TRAILER and DIN are ignored.
- INSTR  input  1  header targets the IR (1) or the DR (0).
- HEADER  input  1  move the TAP from Run-Test-Idle to Shift before shifting.
- TRAILER  input  1  exit on the last bit and return to Run-Test-Idle.
- NBITS  input  4  number of bits minus 1 (0..15).
- DIN  input  16  TDI data, shifted LSB first.
- TDO  input  1  chain TDO.
- TCK  output  1  JTAG clock.
- TMS  output  1  JTAG TMS.
- TDI  output  1  JTAG TDI.
- BUSY  output  1  command in progress.
- DONE  output  1  one-cycle completion pulse.
- TDO_REG  output  16  captured TDO bits.

Behaviour:
- Reset (RST_B=0 at a clock edge): TCK=0, TMS=0, TDI=0, BUSY=0, DONE=0, TDO_REG=0, state IDLE.
- Reset mid-command aborts immediately to the same values; no completion pulse is issued.
- States: IDLE, TRST, HDR, SHIFT, TRL.
- IDLE:
  - STRB=1 latches all command inputs, sets BUSY=1 on the next cycle and clears DONE.
  - If RESET_CMD=1, go to TRST; else if HEADER=1, go to HDR; else go to SHIFT.
  - A shift command (any command with RESET_CMD=0) clears TDO_REG[15:NBITS+1] at the latch.
- STRB while BUSY=1 is ignored; the latched command is not disturbed.
- TCK timing:
  - Each TCK cycle is 2*CLKDIV FPGACLK cycles: TCK low for CLKDIV cycles, then high for CLKDIV cycles.
  - TMS and TDI change only on the first cycle of the low phase.
  - TDO is sampled on the last cycle of the high phase.
- TMS sequence per state:
  - TRST: 6 TCKs with TMS = 1,1,1,1,1,0. The TAP ends in Run-Test-Idle. Go to IDLE.
  - HDR, DR: 3 TCKs with TMS = 1,0,0. HDR, IR: 4 TCKs with TMS = 1,1,0,0. Go to SHIFT.
  - SHIFT: NBITS+1 TCKs.
    - Bit counter k runs 0..NBITS; TDI=DIN_latched[k]; TDO_REG[k] is loaded with the sampled TDO.
    - TMS=0, except TMS=1 on bit k=NBITS when TRAILER=1.
    - Go to TRL if TRAILER=1, else IDLE. The TAP is left in Shift for chained commands.
  - TRL: 2 TCKs with TMS = 1,0 (Update, then Run-Test-Idle). Go to IDLE.
- Completion:
  - BUSY=1 for exactly 2*CLKDIV*N cycles, where N is the total TCK count.
  - DONE=1 for one cycle, the same cycle BUSY returns to 0.
  - TDO_REG is valid when DONE=1 and holds its value until the next shift command.
- TDI returns to 0 and TMS returns to 0 when the block enters IDLE.
- TCK is always 0 in IDLE.
- NBITS=0 is a 1-bit shift.
- A STRB arriving in the same cycle as DONE is accepted. The next command starts its first TCK low phase on the following cycle, so there is no gap TCK.

Test Plan:
- Reset: CLKDIV=2, TDO=0, RST_B=0 for 3 cycles -> TCK=0, TMS=0, TDI=0, BUSY=0, DONE=0, TDO_REG=16'h0000.
- TAP reset: STRB with RESET_CMD=1 -> 6 TCK rising edges, TMS = 1,1,1,1,1,0 at those edges, BUSY high 24 cycles, DONE one pulse.
- DR full shift in loopback (TDO wired to TDI): HEADER=1, TRAILER=1, INSTR=0, NBITS=15, DIN=16'hC3A5 -> TMS 1,0,0, then 15 zeros and a 1, then 1,0; 21 TCKs; BUSY=84 cycles; TDO_REG=16'hC3A5.
- IR short shift, no trailer: TDO held at 1, TDO_REG preloaded to 16'hFFFF, INSTR=1, HEADER=1, TRAILER=0, NBITS=4, DIN=16'h0002 -> TMS 1,1,0,0, then five 0s; TDI bits 0,1,0,0,0; TDO_REG=16'h001F; 9 TCKs.
- Back-to-back commands plus abort:
  - STRB in the DONE cycle -> accepted, no idle TCK.
  - STRB while BUSY -> ignored; TCK count unchanged.
  - RST_B low mid-SHIFT -> all outputs at reset values next cycle, no DONE pulse.
